hilo_ctrl: RTL and testbench

- Sequencer and HI/LO register holder for the 32-bit multiply/divide path.
- Directly downstream of the registered Booth multiplier: it drives stable operands into the multiplier, waits out its latency, and commits the 64-bit product into HI/LO.
- Also performs MIPS-style signed division itself (iterative restoring, 1 bit/cycle).
- HI/LO are read by the datapath for mfhi/mflo; the main control unit stalls on busy.

---
 rtl/hilo_ctrl.sv | 142 ++++++++++++++
 tb/tb_hilo_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: HI/LO holder that sequences the registered multiplier and runs a
// 1-bit/cycle restoring signed divide for the 32-bit mult/div path.
module hilo_ctrl #(
    parameter int MULT_LAT = 2,
    parameter int WIDTH    = 32
) (
    input  logic             clock_i,
    input  logic             reset_ni,
    input  logic             start_mult_i,
    input  logic             start_div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] mult_hi_i,
    input  logic [WIDTH-1:0] mult_low_i,
    output logic [WIDTH-1:0] mult_a_o,
    output logic [WIDTH-1:0] mult_b_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] low_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_zero_o
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, MULT_WAIT, DIV_RUN, DIV_FIX} state_e;
    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mult_a_q, mult_a_d, mult_b_q, mult_b_d, hi_q, hi_d, low_q, low_d;
    logic [WIDTH-1:0] quo_q, quo_d, dvs_q, dvs_d;
    logic [WIDTH:0] rem_q, rem_d;
    logic qneg_q, qneg_d, rneg_q, rneg_d, skip_q, skip_d, done_q, done_d, dz_q, dz_d;
    logic [WIDTH+1:0] trial;

    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mult_a_q <= '0;
            mult_b_q <= '0;
            hi_q     <= '0;
            low_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            skip_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mult_a_q <= mult_a_d;
            mult_b_q <= mult_b_d;
            hi_q     <= hi_d;
            low_q    <= low_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            skip_q   <= skip_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = start_mult_i ? MULT_WAIT :
                                 start_div_i  ? (b_i == '0 ? DIV_FIX : DIV_RUN) : IDLE;
            MULT_WAIT: state_d = cnt_q == '0 ? IDLE : MULT_WAIT;
            DIV_RUN:   state_d = cnt_q == '0 ? DIV_FIX : DIV_RUN;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        mult_a_d = mult_a_q;
        mult_b_d = mult_b_q;
        hi_d     = hi_q;
        low_d    = low_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        skip_d   = skip_q;
        dz_d     = dz_q;
        done_d   = 1'b0;
        // quo_q doubles as the dividend shift register; quotient bits enter at the bottom
        trial    = {rem_q, quo_q[WIDTH-1]} - {2'b0, dvs_q};
        case (state_q)
            IDLE: begin
                if (start_mult_i) begin
                    mult_a_d = a_i;
                    mult_b_d = b_i;
                    cnt_d    = CW'(MULT_LAT - 1);
                    dz_d     = 1'b0;
                end else if (start_div_i) begin
                    quo_d  = a_i[WIDTH-1] ? -a_i : a_i;
                    dvs_d  = b_i[WIDTH-1] ? -b_i : b_i;
                    qneg_d = a_i[WIDTH-1] ^ b_i[WIDTH-1];
                    rneg_d = a_i[WIDTH-1];
                    dz_d   = b_i == '0;
                    skip_d = b_i == '0;
                    rem_d  = '0;
                    cnt_d  = CW'(WIDTH - 1);
                end
            end
            MULT_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    hi_d   = mult_hi_i;
                    low_d  = mult_low_i;
                    done_d = 1'b1;
                end
            end
            DIV_RUN: begin
                cnt_d = cnt_q - CW'(1);
                rem_d = trial[WIDTH+1] ? {rem_q[WIDTH-1:0], quo_q[WIDTH-1]} : trial[WIDTH:0];
                quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH+1]};
            end
            default: begin
                done_d = 1'b1;
                if (!skip_q) begin
                    low_d = qneg_q ? -quo_q : quo_q;
                    hi_d  = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                end
            end
        endcase
    end

    assign mult_a_o   = mult_a_q;
    assign mult_b_o   = mult_b_q;
    assign hi_o       = hi_q;
    assign low_o      = low_q;
    assign busy_o     = state_q != IDLE;
    assign done_o     = done_q;
    assign div_zero_o = dz_q;
endmodule

// File: tb/tb_hilo_ctrl.sv
// tb_hilo_ctrl: directed and random mult/div ops against an arithmetic reference,
// with a registered multiplier model feeding the DUT.
module tb_hilo_ctrl;
    logic        clock = 1'b0, reset_n = 1'b0, start_mult = 1'b0, start_div = 1'b0;
    logic [31:0] a = '0, b = '0, mult_hi, mult_low, mult_a, mult_b, hi, low;
    logic        busy, done, div_zero;
    logic [63:0] prod = '0;
    int          passed = 0, total = 0;
    logic [31:0] exp_hi = '0, exp_lo = '0, last_ma = '0, last_mb = '0;

    always #5 clock = ~clock;

    always @(posedge clock) prod <= longint'($signed(mult_a)) * longint'($signed(mult_b));
    assign mult_hi  = prod[63:32];
    assign mult_low = prod[31:0];

    hilo_ctrl dut (
        .clock_i(clock), .reset_ni(reset_n), .start_mult_i(start_mult), .start_div_i(start_div),
        .a_i(a), .b_i(b), .mult_hi_i(mult_hi), .mult_low_i(mult_low),
        .mult_a_o(mult_a), .mult_b_o(mult_b), .hi_o(hi), .low_o(low),
        .busy_o(busy), .done_o(done), .div_zero_o(div_zero)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic op(input string tag, input bit is_mult, input bit both,
                      input logic [31:0] x, input logic [31:0] y, input int col);
        longint      sx, sy, q, r;
        logic [63:0] p;
        logic [31:0] eh, el;
        logic        edz;
        int          lat, n;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (is_mult) begin
            p = sx * sy; eh = p[63:32]; el = p[31:0]; lat = 2; edz = 1'b0;
            last_ma = x; last_mb = y;
        end else if (y == 0) begin
            eh = exp_hi; el = exp_lo; lat = 1; edz = 1'b1;
        end else begin
            q = sx / sy; r = sx % sy; el = q[31:0]; eh = r[31:0]; lat = 33; edz = 1'b0;
        end
        a = x; b = y; start_mult = is_mult | both; start_div = !is_mult | both;
        tick();
        start_mult = 1'b0; start_div = 1'b0; a = $urandom(); b = $urandom();
        check({tag, "/busy0"}, 32'(busy), 32'd1);
        n = 0;
        do begin
            start_mult = (n + 1 == col);
            tick();
            n++;
            start_mult = 1'b0;
            check({tag, "/busy"}, 32'(busy), 32'(!done));
        end while (!done && n < 40);
        check({tag, "/lat"}, 32'(n), 32'(lat));
        check({tag, "/hi"}, hi, eh);
        check({tag, "/low"}, low, el);
        check({tag, "/dz"}, 32'(div_zero), 32'(edz));
        check({tag, "/ma"}, mult_a, last_ma);
        check({tag, "/mb"}, mult_b, last_mb);
        tick();
        check({tag, "/pulse"}, 32'(done), 32'd0);
        check({tag, "/hold"}, hi, eh);
        exp_hi = eh;
        exp_lo = el;
    endtask

    initial begin
        logic [31:0] rx, ry;
        bit          rm;
        repeat (2) tick();
        check("rst/hi", hi, 32'd0);
        check("rst/low", low, 32'd0);
        check("rst/busy", 32'(busy), 32'd0);
        check("rst/done", 32'(done), 32'd0);
        check("rst/dz", 32'(div_zero), 32'd0);
        check("rst/ma", mult_a, 32'd0);
        reset_n = 1'b1;
        tick();
        check("idle/busy", 32'(busy), 32'd0);

        op("mul_7x-7", 1, 0, 32'd7, 32'hFFFF_FFF9, -1);
        op("div_-7/2", 0, 0, 32'hFFFF_FFF9, 32'd2, -1);
        op("div_100/7", 0, 0, 32'd100, 32'd7, -1);
        op("mul_3x5", 1, 0, 32'd3, 32'd5, -1);
        op("div_9/0", 0, 0, 32'd9, 32'd0, -1);
        repeat (3) tick();
        check("dz/sticky", 32'(div_zero), 32'd1);
        check("dz/low", low, 32'd15);
        op("div_ovf", 0, 0, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        op("div_min/min", 0, 0, 32'h8000_0000, 32'h8000_0000, -1);
        op("div_collide", 0, 0, 32'd100, 32'd7, 5);
        op("mul_collide", 1, 0, 32'h1234_5678, 32'hFEDC_BA98, 1);
        op("both", 1, 1, 32'd6, 32'hFFFF_FFF7, -1);

        a = 32'd100; b = 32'd7; start_div = 1'b1;
        tick();
        start_div = 1'b0;
        repeat (9) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("midrst/hi", hi, 32'd0);
        check("midrst/low", low, 32'd0);
        check("midrst/busy", 32'(busy), 32'd0);
        check("midrst/done", 32'(done), 32'd0);
        check("midrst/dz", 32'(div_zero), 32'd0);
        check("midrst/ma", mult_a, 32'd0);
        repeat (3) begin
            tick();
            check("midrst/nodone", 32'(done), 32'd0);
        end
        exp_hi = '0; exp_lo = '0; last_ma = '0; last_mb = '0;
        op("div_after_rst", 0, 0, 32'hFFFF_FF9C, 32'd7, -1);

        for (int i = 0; i < 16; i++) begin
            rm = 1'($urandom_range(0, 1));
            rx = $urandom();
            ry = ($urandom_range(0, 5) == 0) ? 32'd0 :
                 ($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(1, 20));
            if ($urandom_range(0, 1) == 1) ry = -ry;
            op(rm ? "rnd_mul" : "rnd_div", rm, 0, rx, ry, -1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
